mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256: data memory size in 32-bit words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: extra cycles per load/store, 0..15.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  in  1  EX/MEM entry holds a real instruction.
REQ-006 ctlwb_in  in  2  WB control from EX/MEM.
REQ-007 branch, memread, memwrite  in  1 each  MEM control from EX/MEM.
REQ-008 add_result  in  32  branch target; zero  in  1  ALU zero flag.
REQ-009 alu_result  in  32  ALU output or byte address; rdata2  in  32  store data; muxout  in  5  destination register.
REQ-010 pcsrc  out  1  take branch; branch_target  out  32  equals add_result.
REQ-011 stall  out  1  upstream holds EX/MEM and PC this cycle.
REQ-012 out_valid  out  1; wb_ctlout  out  2; read_data  out  32; alu_result_out  out  32; muxout_out  out  5  MEM/WB register.
REQ-013 misalign  out  1  registered alignment-fault flag (only with MEM_ALIGN_CHECK_EN).

Function
REQ-014 Memop: in_valid & (memread | memwrite).
REQ-015 Word index: alu_result[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-016 pcsrc is combinational: in_valid & branch & zero & ~stall. branch_target = add_result.
REQ-017 FSM states IDLE and ACCESS, plus a 4-bit counter cnt.
REQ-018 IDLE, non-memop: stall=0. The MEM/WB register loads at the next edge, giving 1-cycle latency.
REQ-019 IDLE, memop, WAIT_CYCLES=0: behaves like REQ-018, with the memory access at that edge.
REQ-020 IDLE, memop, WAIT_CYCLES>0: stall=1; go to ACCESS with cnt=1. MEM/WB loads a bubble (out_valid=0, wb_ctlout=0).
REQ-021 ACCESS, cnt<WAIT_CYCLES: stall=1; cnt increments; MEM/WB loads a bubble.
REQ-022 ACCESS, cnt==WAIT_CYCLES: stall=0; memory access and MEM/WB load occur at that edge; return to IDLE. Total memop latency is WAIT_CYCLES+1 cycles.
REQ-023 Upstream holds all inputs stable while stall=1. Inputs are sampled only in the completion cycle.
REQ-024 Store: mem[index] <= rdata2 at the completion edge only.
REQ-025 Load: read_data <= mem[index] at the completion edge. For a non-load, read_data <= 0.
REQ-026 memread & memwrite both set: the write executes and read_data <= 0.
REQ-027 A load from the address just stored reads the new value. Stores complete before the next instruction is accepted.
REQ-028 Pass-through on load: wb_ctlout <= ctlwb_in, alu_result_out <= alu_result, muxout_out <= muxout, out_valid <= in_valid.
REQ-029 in_valid=0: no memory access; stall=0; out_valid <= 0.

Reset
REQ-030 reset low: FSM=IDLE, cnt=0, all MEM/WB outputs 0, misalign=0, immediately and asynchronously.
REQ-031 Memory contents are not cleared by reset.
REQ-032 Reset during ACCESS abandons the access. A pending store is never committed.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN.
- Defined: a memop with alu_result[1:0]!=0 suppresses the store, forces read_data=0, and registers misalign=1 with that MEM/WB entry. misalign=0 otherwise.
- Undefined: low address bits are ignored and misalign is tied 0.

Structure
REQ-034 Shared package mips_pkg holds the FSM state enum, WB/MEM control widths, and constant WORD_BYTES=4.
REQ-035 One sub-module, data_mem: synchronous single-port 32-bit RAM with write enable, parameter DEPTH, no reset.

Verification
REQ-036 WAIT_CYCLES=2: store 0xDEADBEEF to address 0x10.
- Response: stall=1 for 2 cycles then 0.
- Response: out_valid=1 on the 3rd edge.
- Follow-up: a load from 0x10 returns 0xDEADBEEF.
REQ-037 Non-memop R-type, alu_result=0x25, muxout=9.
- Response: next cycle alu_result_out=0x25, muxout_out=9, out_valid=1, stall=0.
REQ-038 branch=1, zero=1, add_result=0x40.
- Response: pcsrc=1 and branch_target=0x40 in the same cycle.
- With zero=0: pcsrc=0.
REQ-039 Store 0x1234 to address DEPTH*4+8.
- Response: a load from address 8 returns 0x1234 (wrap).
REQ-040 Assert reset in the 2nd stall cycle of a store of 0xAAAA to 0x20.
- Response: all outputs 0 at once.
- Follow-up: a later load from 0x20 returns the prior contents.
REQ-041 MEM_ALIGN_CHECK_EN defined: store to 0x13.
- Response: misalign=1; memory unchanged.
- Undefined: the store lands at word 0x10.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MEM pipeline stage
// Contents: MEM-stage FSM state enum, WB/MEM control field widths, word size in bytes.
package mips_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    localparam int WB_W       = 2;
    localparam int MEM_W      = 3;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/data_mem.sv
// data_mem: synchronous single-port 32-bit RAM, registered read, no reset
// Ports: clk, we (write enable), addr (word index), wdata (write data),
//        rdata (word at addr as of the last edge; old contents on a same-edge write).
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM pipeline stage with multi-cycle data memory and MEM/WB register
// Parameters: DEPTH (words, power of two), WAIT_CYCLES (extra cycles per load/store, 0..15).
// Inputs : clk, reset (async, active-low), in_valid, ctlwb_in, branch, memread, memwrite,
//          add_result, zero, alu_result, rdata2, muxout (EX/MEM register fields).
// Outputs: pcsrc, branch_target (combinational branch decision), stall (hold upstream),
//          out_valid, wb_ctlout, read_data, alu_result_out, muxout_out, misalign (MEM/WB).
// Build option: define MEM_ALIGN_CHECK_EN to fault misaligned loads/stores; otherwise
//          the low two address bits are ignored and misalign stays 0.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [WB_W-1:0] ctlwb_in,
    input  logic            branch,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [31:0]     add_result,
    input  logic            zero,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     rdata2,
    input  logic [4:0]      muxout,
    output logic            pcsrc,
    output logic [31:0]     branch_target,
    output logic            stall,
    output logic            out_valid,
    output logic [WB_W-1:0] wb_ctlout,
    output logic [31:0]     read_data,
    output logic [31:0]     alu_result_out,
    output logic [4:0]      muxout_out,
    output logic            misalign
);

    localparam int         AW  = $clog2(DEPTH);
    localparam int         OFF = $clog2(WORD_BYTES);
    localparam logic [3:0] WC  = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WB_W-1:0]   wb_ctl_q, wb_ctl_d;
    logic [31:0]       alu_q, alu_d;
    logic [4:0]        mux_q, mux_d;
    logic              rd_sel_q, rd_sel_d;
    logic              misalign_q, misalign_d;
    logic              memop, done, mis, we;
    logic [AW-1:0]     idx;
    logic [31:0]       rdata;

    assign memop = in_valid & (memread | memwrite);
    assign idx   = alu_result[AW+OFF-1:OFF];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = memop & (alu_result[OFF-1:0] != '0);
`else
    assign mis = 1'b0;
`endif

    // done marks the cycle whose closing edge performs the access and loads MEM/WB
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        if (state_q == IDLE) begin
            if (memop && WC != 4'd0) begin
                stall   = 1'b1;
                state_d = ACCESS;
                cnt_d   = 4'd1;
            end else begin
                done = 1'b1;
            end
        end else if (cnt_q < WC) begin
            stall = 1'b1;
            cnt_d = cnt_q + 4'd1;
        end else begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    // stall cycles load an all-zero bubble into MEM/WB
    always_comb begin
        out_valid_d = done & in_valid;
        wb_ctl_d    = done ? ctlwb_in : '0;
        alu_d       = done ? alu_result : '0;
        mux_d       = done ? muxout : '0;
        rd_sel_d    = done & in_valid & memread & ~memwrite & ~mis;
        misalign_d  = done & mis;
        we          = done & in_valid & memwrite & ~mis;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            wb_ctl_q    <= '0;
            alu_q       <= '0;
            mux_q       <= '0;
            rd_sel_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            wb_ctl_q    <= wb_ctl_d;
            alu_q       <= alu_d;
            mux_q       <= mux_d;
            rd_sel_q    <= rd_sel_d;
            misalign_q  <= misalign_d;
        end
    end

    data_mem #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (we),
        .addr (idx),
        .wdata(rdata2),
        .rdata(rdata)
    );

    // the RAM reads every cycle; rd_sel_q marks when its output is a real load result
    assign read_data      = rd_sel_q ? rdata : '0;
    assign pcsrc          = in_valid & branch & zero & ~stall;
    assign branch_target  = add_result;
    assign out_valid      = out_valid_q;
    assign wb_ctlout      = wb_ctl_q;
    assign alu_result_out = alu_q;
    assign muxout_out     = mux_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage against a word-array memory model
module tb_mem_stage;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  ctlwb_in = '0;
    logic        branch = 1'b0, memread = 1'b0, memwrite = 1'b0, zero = 1'b0;
    logic [31:0] add_result = '0, alu_result = '0, rdata2 = '0;
    logic [4:0]  muxout = '0;
    logic        pcsrc, stall, out_valid, misalign;
    logic [31:0] branch_target, read_data, alu_result_out;
    logic [1:0]  wb_ctlout;
    logic [4:0]  muxout_out;

    int          total = 0;
    int          bad = 0;
    int          obs_stalls;
    logic        obs_pc;
    logic [31:0] obs_bt;
    logic [31:0] ref_mem [DEPTH];
    bit          written [DEPTH];

    mem_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ctlwb_in(ctlwb_in),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2(rdata2), .muxout(muxout), .pcsrc(pcsrc), .branch_target(branch_target),
        .stall(stall), .out_valid(out_valid), .wb_ctlout(wb_ctlout),
        .read_data(read_data), .alu_result_out(alu_result_out),
        .muxout_out(muxout_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Presents one instruction, waits out its stall (bounded), records the
    // combinational branch outputs in the completion cycle, then steps past the
    // completing edge so MEM/WB can be inspected.
    task automatic run_op(input logic v, br, mr, mw, z, input logic [31:0] a, wd, tgt,
                          input logic [1:0] ctl, input logic [4:0] mx);
        @(negedge clk);
        in_valid = v; branch = br; memread = mr; memwrite = mw; zero = z;
        alu_result = a; rdata2 = wd; add_result = tgt; ctlwb_in = ctl; muxout = mx;
        #1;
        obs_stalls = 0;
        while (stall === 1'b1 && obs_stalls < 40) begin
            @(posedge clk); #1;
            obs_stalls++;
        end
        obs_pc = pcsrc;
        obs_bt = branch_target;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_read_data got=%h want=0", read_data); end
        total++; if (alu_result_out !== 32'h0 || muxout_out !== 5'h0 || wb_ctlout !== 2'h0) begin
            bad++; $display("FAIL reset_fields got=%h/%h/%h want=0", alu_result_out, muxout_out, wb_ctlout); end
        total++; if (misalign !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", misalign, stall); end
        @(negedge clk) reset = 1'b1;
        run_op(1, 0, 0, 0, 0, 32'h77, 0, 0, 2'b11, 5'd3);
        total++; if (alu_result_out !== 32'h77) begin bad++; $display("FAIL pre_async got=%h want=77", alu_result_out); end
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || alu_result_out !== 32'h0 || wb_ctlout !== 2'h0 || muxout_out !== 5'h0) begin
            bad++; $display("FAIL async_reset got=%b/%h/%h/%h want=0", out_valid, alu_result_out, wb_ctlout, muxout_out); end
        @(negedge clk) begin reset = 1'b1; in_valid = 1'b0; end
    endtask

    task automatic test_rtype;
        run_op(1, 0, 0, 0, 0, 32'h25, 32'h0, 32'h0, 2'b10, 5'd9);
        total++; if (obs_stalls !== 0) begin bad++; $display("FAIL rtype_stall got=%0d want=0", obs_stalls); end
        total++; if (alu_result_out !== 32'h25) begin bad++; $display("FAIL rtype_alu got=%h want=25", alu_result_out); end
        total++; if (muxout_out !== 5'd9) begin bad++; $display("FAIL rtype_mux got=%0d want=9", muxout_out); end
        total++; if (out_valid !== 1'b1 || wb_ctlout !== 2'b10) begin bad++; $display("FAIL rtype_valid got=%b/%b want=1/10", out_valid, wb_ctlout); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rtype_rdata got=%h want=0", read_data); end
    endtask

    task automatic test_branch;
        run_op(1, 1, 0, 0, 1, 32'h0, 32'h0, 32'h40, 2'b00, 5'd0);
        total++; if (obs_pc !== 1'b1) begin bad++; $display("FAIL branch_taken got=%b want=1", obs_pc); end
        total++; if (obs_bt !== 32'h40) begin bad++; $display("FAIL branch_target got=%h want=40", obs_bt); end
        run_op(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h40, 2'b00, 5'd0);
        total++; if (obs_pc !== 1'b0) begin bad++; $display("FAIL branch_nz got=%b want=0", obs_pc); end
        run_op(0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h80, 2'b00, 5'd0);
        total++; if (obs_pc !== 1'b0) begin bad++; $display("FAIL branch_invalid got=%b want=0", obs_pc); end
    endtask

    task automatic test_store_load;
        ref_mem[widx(32'h10)] = 32'hDEADBEEF; written[widx(32'h10)] = 1'b1;
        run_op(1, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 2'b00, 5'd0);
        total++; if (obs_stalls !== WAITC) begin bad++; $display("FAIL store_stall got=%0d want=%0d", obs_stalls, WAITC); end
        total++; if (out_valid !== 1'b1 || read_data !== 32'h0) begin bad++; $display("FAIL store_out got=%b/%h want=1/0", out_valid, read_data); end
        run_op(1, 0, 1, 0, 0, 32'h10, 32'h0, 0, 2'b11, 5'd4);
        total++; if (read_data !== ref_mem[widx(32'h10)]) begin bad++; $display("FAIL load_10 got=%h want=%h", read_data, ref_mem[widx(32'h10)]); end
        total++; if (obs_stalls !== WAITC) begin bad++; $display("FAIL load_stall got=%0d want=%0d", obs_stalls, WAITC); end
        ref_mem[widx(32'h14)] = 32'h0BADF00D; written[widx(32'h14)] = 1'b1;
        run_op(1, 0, 1, 1, 0, 32'h14, 32'h0BADF00D, 0, 2'b11, 5'd5);
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rw_both got=%h want=0", read_data); end
        run_op(1, 0, 1, 0, 0, 32'h14, 32'h0, 0, 2'b11, 5'd5);
        total++; if (read_data !== ref_mem[widx(32'h14)]) begin bad++; $display("FAIL rw_both_load got=%h want=%h", read_data, ref_mem[widx(32'h14)]); end
    endtask

    task automatic test_wrap;
        ref_mem[widx(DEPTH * 4 + 8)] = 32'h1234; written[widx(DEPTH * 4 + 8)] = 1'b1;
        run_op(1, 0, 0, 1, 0, DEPTH * 4 + 8, 32'h1234, 0, 2'b00, 5'd0);
        run_op(1, 0, 1, 0, 0, 32'h8, 32'h0, 0, 2'b01, 5'd2);
        total++; if (read_data !== ref_mem[widx(32'h8)]) begin bad++; $display("FAIL wrap got=%h want=%h", read_data, ref_mem[widx(32'h8)]); end
    endtask

    task automatic test_abort;
        ref_mem[widx(32'h20)] = 32'h5555; written[widx(32'h20)] = 1'b1;
        run_op(1, 0, 0, 1, 0, 32'h20, 32'h5555, 0, 2'b00, 5'd0);
        @(negedge clk);
        in_valid = 1'b1; memwrite = 1'b1; memread = 1'b0; alu_result = 32'h20; rdata2 = 32'hAAAA;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || read_data !== 32'h0 || alu_result_out !== 32'h0 || misalign !== 1'b0) begin
            bad++; $display("FAIL abort_outputs got=%b/%h/%h/%b want=0", out_valid, read_data, alu_result_out, misalign); end
        @(negedge clk) begin in_valid = 1'b0; memwrite = 1'b0; end
        @(negedge clk) reset = 1'b1;
        run_op(1, 0, 1, 0, 0, 32'h20, 32'h0, 0, 2'b01, 5'd1);
        total++; if (read_data !== ref_mem[widx(32'h20)]) begin bad++; $display("FAIL abort_mem got=%h want=%h", read_data, ref_mem[widx(32'h20)]); end
    endtask

    task automatic test_align;
        run_op(1, 0, 0, 1, 0, 32'h13, 32'hCAFE, 0, 2'b00, 5'd0);
`ifdef MEM_ALIGN_CHECK_EN
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL align_flag got=%b want=1", misalign); end
`else
        ref_mem[widx(32'h13)] = 32'hCAFE; written[widx(32'h13)] = 1'b1;
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL align_flag got=%b want=0", misalign); end
`endif
        run_op(1, 0, 1, 0, 0, 32'h10, 32'h0, 0, 2'b01, 5'd1);
        total++; if (read_data !== ref_mem[widx(32'h10)]) begin bad++; $display("FAIL align_mem got=%h want=%h", read_data, ref_mem[widx(32'h10)]); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL align_clear got=%b want=0", misalign); end
    endtask

    task automatic test_invalid;
        run_op(0, 0, 0, 1, 0, 32'h10, 32'h999, 0, 2'b11, 5'd7);
        total++; if (obs_stalls !== 0 || out_valid !== 1'b0) begin bad++; $display("FAIL invalid_store got=%0d/%b want=0/0", obs_stalls, out_valid); end
        run_op(1, 0, 1, 0, 0, 32'h10, 32'h0, 0, 2'b01, 5'd1);
        total++; if (read_data !== ref_mem[widx(32'h10)]) begin bad++; $display("FAIL invalid_mem got=%h want=%h", read_data, ref_mem[widx(32'h10)]); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            a = 32'h100 + 32'(i * 4);
            d = $urandom();
            ref_mem[widx(a)] = d; written[widx(a)] = 1'b1;
            run_op(1, 0, 0, 1, 0, a, d, 0, 2'b00, 5'd0);
            run_op(1, 0, 1, 0, 0, a, 32'h0, 0, 2'b11, 5'(i));
            total++; if (read_data !== d) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, read_data, d); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic        v, br, mr, mw, z;
            logic [31:0] a, wd, tgt, er;
            logic [1:0]  ctl;
            logic [4:0]  mx;
            int          k, ix, es;
            k   = $urandom_range(0, 4);
            a   = $urandom() & 32'hFFFF_FFFC;
            ix  = widx(a);
            v   = (k != 4);
            br  = (k == 3);
            z   = 1'($urandom_range(0, 1));
            mr  = (k == 1) && written[ix];
            mw  = (k == 2) || (k == 1 && !written[ix]) || (k == 4 && $urandom_range(0, 1) == 1);
            wd  = $urandom();
            tgt = $urandom();
            ctl = 2'($urandom());
            mx  = 5'($urandom());
            er  = (v && mr && !mw) ? ref_mem[ix] : 32'h0;
            es  = (v && (mr || mw)) ? WAITC : 0;
            if (v && mw) begin ref_mem[ix] = wd; written[ix] = 1'b1; end
            run_op(v, br, mr, mw, z, a, wd, tgt, ctl, mx);
            total++; if (obs_stalls !== es) begin bad++; $display("FAIL rnd%0d_stall got=%0d want=%0d", i, obs_stalls, es); end
            total++; if (obs_pc !== (v & br & z) || obs_bt !== tgt) begin
                bad++; $display("FAIL rnd%0d_branch got=%b/%h want=%b/%h", i, obs_pc, obs_bt, v & br & z, tgt); end
            total++; if (out_valid !== v) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", i, out_valid, v); end
            if (v) begin
                total++; if (read_data !== er) begin bad++; $display("FAIL rnd%0d_rdata got=%h want=%h", i, read_data, er); end
                total++; if (alu_result_out !== a || muxout_out !== mx || wb_ctlout !== ctl) begin
                    bad++; $display("FAIL rnd%0d_pass got=%h/%h/%h want=%h/%h/%h", i, alu_result_out, muxout_out, wb_ctlout, a, mx, ctl); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_branch;
        test_store_load;
        test_wrap;
        test_abort;
        test_align;
        test_invalid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
